// File: rtl/mips_mc_control_fsm.sv
// mips_mc_control_fsm
// Main control unit for the multi-cycle, non-pipelined MIPS core.
// A Moore FSM steps each instruction through fetch/decode/execute/memory/
// writeback and drives the datapath selects and write enables.
// Every memory access waits on a ready handshake with a timeout. An
// undefined opcode raises illegal_op_o, and a memory timeout raises bus_err_o.
// Optional build macro: BNE_EN adds the BNE opcode (000101) and the
// branch_ne_o output.
module mips_mc_control_fsm #(
  parameter int MIPS_OP_WIDTH = 6,
  parameter int MEM_TIMEOUT   = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [MIPS_OP_WIDTH-1:0] op_i,
  input  logic                     mem_ready_i,
  output logic                     pc_write_o,
  output logic                     branch_o,
  output logic                     iord_o,
  output logic                     mem_write_o,
  output logic                     ir_write_o,
  output logic                     reg_dst_o,
  output logic                     mem_to_reg_o,
  output logic                     reg_write_o,
  output logic                     alu_src_a_o,
  output logic [1:0]               alu_src_b_o,
  output logic [1:0]               alu_op_o,
  output logic [1:0]               pc_src_o,
  output logic                     illegal_op_o,
  output logic                     bus_err_o,
`ifdef BNE_EN
  output logic                     branch_ne_o,
`endif
  output logic [3:0]               state_o
);

  // Timeout counter sized to hold the value MEM_TIMEOUT itself
  localparam int TO_CNT_WIDTH = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_CNT_WIDTH-1:0] TO_LIMIT = TO_CNT_WIDTH'(MEM_TIMEOUT);

  // Opcode field values
  localparam logic [MIPS_OP_WIDTH-1:0] OP_RTYPE = MIPS_OP_WIDTH'(6'b000000);
  localparam logic [MIPS_OP_WIDTH-1:0] OP_LW    = MIPS_OP_WIDTH'(6'b100011);
  localparam logic [MIPS_OP_WIDTH-1:0] OP_SW    = MIPS_OP_WIDTH'(6'b101011);
  localparam logic [MIPS_OP_WIDTH-1:0] OP_BEQ   = MIPS_OP_WIDTH'(6'b000100);
  localparam logic [MIPS_OP_WIDTH-1:0] OP_ADDI  = MIPS_OP_WIDTH'(6'b001000);
  localparam logic [MIPS_OP_WIDTH-1:0] OP_J     = MIPS_OP_WIDTH'(6'b000010);
`ifdef BNE_EN
  localparam logic [MIPS_OP_WIDTH-1:0] OP_BNE   = MIPS_OP_WIDTH'(6'b000101);
`endif

  // The encodings are visible on state_o, so they are fixed explicitly
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_BNE    = 4'd12
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic [TO_CNT_WIDTH-1:0] to_cnt_reg;
  logic [TO_CNT_WIDTH-1:0] to_cnt_next;
  logic                    timeout;

  // Write enables before reset gating
  logic pc_write_raw;
  logic branch_raw;
  logic mem_write_raw;
  logic ir_write_raw;
  logic reg_write_raw;
`ifdef BNE_EN
  logic branch_ne_raw;
`endif

  // Selects and flags
  logic       iord;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       illegal_op;
  logic       bus_err;

  // The wait budget is used up when the counter reaches the limit. In that
  // same cycle, ready still takes priority over the timeout.
  assign timeout = (to_cnt_reg == TO_LIMIT);

  // State and timeout counter registers. Reset is asynchronous, so an
  // instruction in flight is abandoned immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_FETCH;
      to_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      to_cnt_reg <= to_cnt_next;
    end
  end

  // Next-state logic and per-state datapath controls. The counter defaults to
  // zero, so it only keeps counting while the FSM stays in a wait state.
  always_comb begin
    state_next    = state_reg;
    to_cnt_next   = '0;
    pc_write_raw  = 1'b0;
    branch_raw    = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
`ifdef BNE_EN
    branch_ne_raw = 1'b0;
`endif
    iord          = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_src        = 2'b00;
    illegal_op    = 1'b0;
    bus_err       = 1'b0;

    case (state_reg)
      S_FETCH: begin
        // PC + 4 is computed while the instruction is read
        alu_src_b = 2'b01;
        if (mem_ready_i) begin
          ir_write_raw = 1'b1;
          pc_write_raw = 1'b1;
          state_next   = S_DECODE;
        end else if (timeout) begin
          bus_err    = 1'b1;
          state_next = S_FETCH;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end

      S_DECODE: begin
        // Branch target is computed speculatively during decode
        alu_src_b = 2'b11;
        case (op_i)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
`ifdef BNE_EN
          OP_BNE:       state_next = S_BNE;
`endif
          default: begin
            illegal_op = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (op_i == OP_LW) begin
          state_next = S_MEMRD;
        end else if (op_i == OP_SW) begin
          state_next = S_MEMWR;
        end else begin
          state_next = S_FETCH;
        end
      end

      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready_i) begin
          state_next = S_MEMWB;
        end else if (timeout) begin
          bus_err    = 1'b1;
          state_next = S_FETCH;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end

      S_MEMWB: begin
        mem_to_reg    = 1'b1;
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end

      S_MEMWR: begin
        // The strobe is held until memory accepts the write, but it is
        // dropped in the cycle that gives up on the access
        iord = 1'b1;
        if (mem_ready_i) begin
          mem_write_raw = 1'b1;
          state_next    = S_FETCH;
        end else if (timeout) begin
          bus_err    = 1'b1;
          state_next = S_FETCH;
        end else begin
          mem_write_raw = 1'b1;
          to_cnt_next   = to_cnt_reg + 1'b1;
        end
      end

      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b00;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end

      S_ALUWB: begin
        reg_dst       = 1'b1;
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        branch_raw = 1'b1;
        state_next = S_FETCH;
      end

      S_ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = S_ADDIWB;
      end

      S_ADDIWB: begin
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end

      S_JUMP: begin
        pc_src       = 2'b10;
        pc_write_raw = 1'b1;
        state_next   = S_FETCH;
      end

`ifdef BNE_EN
      S_BNE: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_src        = 2'b01;
        branch_ne_raw = 1'b1;
        state_next    = S_FETCH;
      end
`endif

      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // Write enables are gated with rst_n, so nothing is written while reset is
  // low. This includes the cycle in which reset falls.
  assign pc_write_o   = pc_write_raw  & rst_n;
  assign branch_o     = branch_raw    & rst_n;
  assign mem_write_o  = mem_write_raw & rst_n;
  assign ir_write_o   = ir_write_raw  & rst_n;
  assign reg_write_o  = reg_write_raw & rst_n;
`ifdef BNE_EN
  assign branch_ne_o  = branch_ne_raw & rst_n;
`endif

  assign iord_o       = iord;
  assign reg_dst_o    = reg_dst;
  assign mem_to_reg_o = mem_to_reg;
  assign alu_src_a_o  = alu_src_a;
  assign alu_src_b_o  = alu_src_b;
  assign alu_op_o     = alu_op;
  assign pc_src_o     = pc_src;
  assign illegal_op_o = illegal_op;
  assign bus_err_o    = bus_err;
  assign state_o      = state_reg;

endmodule

// File: tb/tb_mips_mc_control_fsm.sv
// Testbench for mips_mc_control_fsm.
// An instruction-level model expands each (opcode, fetch wait, data wait)
// into the expected per-cycle sequence of states and controls. That sequence
// then drives the DUT and is compared against it cycle by cycle. A table of
// directed instructions also checks per-instruction tallies. Hand-written
// sequences cover reset.
module tb_mips_mc_control_fsm;

  localparam int MEM_TIMEOUT = 15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op_i;
  logic       mem_ready_i;
  logic       pc_write_o, branch_o, iord_o, mem_write_o, ir_write_o;
  logic       reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o;
  logic [1:0] alu_src_b_o, alu_op_o, pc_src_o;
  logic       illegal_op_o, bus_err_o;
  logic       branch_ne_w;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  mips_mc_control_fsm #(
    .MIPS_OP_WIDTH(6),
    .MEM_TIMEOUT  (MEM_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_i        (op_i),
    .mem_ready_i (mem_ready_i),
    .pc_write_o  (pc_write_o),
    .branch_o    (branch_o),
    .iord_o      (iord_o),
    .mem_write_o (mem_write_o),
    .ir_write_o  (ir_write_o),
    .reg_dst_o   (reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o),
    .reg_write_o (reg_write_o),
    .alu_src_a_o (alu_src_a_o),
    .alu_src_b_o (alu_src_b_o),
    .alu_op_o    (alu_op_o),
    .pc_src_o    (pc_src_o),
    .illegal_op_o(illegal_op_o),
    .bus_err_o   (bus_err_o),
`ifdef BNE_EN
    .branch_ne_o (branch_ne_w),
`endif
    .state_o     (state_o)
  );

`ifndef BNE_EN
  assign branch_ne_w = 1'b0;
`endif

  typedef struct packed {
    logic       pcw, br, brne, iord, mw, irw, rd, m2r, rw, asa;
    logic [1:0] asb, aop, psrc;
    logic       ill, berr;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic       rdy;
    logic [3:0] st;
    outs_t      o;
  } cyc_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    int         fw, mw;
    int         busy, rw, mwc, irw, ill, berr;
  } row_t;

  cyc_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic outs_t z();
    outs_t o;
    o = '0;
    return o;
  endfunction

  function automatic outs_t dut_outs();
    outs_t o;
    o.pcw  = pc_write_o;   o.br   = branch_o;     o.brne = branch_ne_w;
    o.iord = iord_o;       o.mw   = mem_write_o;  o.irw  = ir_write_o;
    o.rd   = reg_dst_o;    o.m2r  = mem_to_reg_o; o.rw   = reg_write_o;
    o.asa  = alu_src_a_o;  o.asb  = alu_src_b_o;  o.aop  = alu_op_o;
    o.psrc = pc_src_o;     o.ill  = illegal_op_o; o.berr = bus_err_o;
    return o;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    bit l;
    l = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
        (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
`ifdef BNE_EN
    l = l || (op == OP_BNE);
`endif
    return l;
  endfunction

  task automatic push(input logic [5:0] op, input logic rdy, input int st, input outs_t o);
    cyc_t c;
    c.op  = op;
    c.rdy = rdy;
    c.st  = 4'(st);
    c.o   = o;
    exp_q.push_back(c);
  endtask

  // A non-memory cycle: ready is irrelevant, so it is randomised
  task automatic step(input logic [5:0] op, input int st, input outs_t o);
    push(op, 1'($urandom_range(0, 1)), st, o);
  endtask

  // A memory access that sees 'waits' not-ready cycles before ready. If the
  // wait exceeds the budget, it ends in a bus-error cycle instead.
  task automatic mem_phase(input logic [5:0] op, input int st, input int waits,
                           input outs_t w_o, input outs_t d_o, input outs_t t_o,
                           output bit ok);
    int n;
    n = (waits > MEM_TIMEOUT) ? MEM_TIMEOUT : waits;
    for (int i = 0; i < n; i++) push(op, 1'b0, st, w_o);
    if (waits > MEM_TIMEOUT) begin
      push(op, 1'b0, st, t_o);
      ok = 1'b0;
    end else begin
      push(op, 1'b1, st, d_o);
      ok = 1'b1;
    end
  endtask

  // Expand one instruction into its expected cycle sequence
  task automatic add_instr(input logic [5:0] op, input int fw, input int mw);
    outs_t w, d, t, o;
    bit ok;
    w = z(); w.asb = 2'b01;
    d = w;   d.irw = 1'b1; d.pcw = 1'b1;
    t = w;   t.berr = 1'b1;
    mem_phase(op, 0, fw, w, d, t, ok);
    if (!ok) return;
    o = z(); o.asb = 2'b11;
    if (!is_legal(op)) begin
      o.ill = 1'b1;
      step(op, 1, o);
      return;
    end
    step(op, 1, o);
    if (op == OP_LW || op == OP_SW) begin
      o = z(); o.asa = 1'b1; o.asb = 2'b10;
      step(op, 2, o);
      if (op == OP_LW) begin
        w = z(); w.iord = 1'b1;
        t = w;   t.berr = 1'b1;
        mem_phase(op, 3, mw, w, w, t, ok);
        if (!ok) return;
        o = z(); o.m2r = 1'b1; o.rw = 1'b1;
        step(op, 4, o);
      end else begin
        w = z(); w.iord = 1'b1; w.mw = 1'b1;
        t = z(); t.iord = 1'b1; t.berr = 1'b1;
        mem_phase(op, 5, mw, w, w, t, ok);
      end
    end else if (op == OP_RTYPE) begin
      o = z(); o.asa = 1'b1; o.aop = 2'b10;
      step(op, 6, o);
      o = z(); o.rd = 1'b1; o.rw = 1'b1;
      step(op, 7, o);
    end else if (op == OP_BEQ || op == OP_BNE) begin
      o = z(); o.asa = 1'b1; o.aop = 2'b01; o.psrc = 2'b01;
      if (op == OP_BEQ) o.br = 1'b1;
      else              o.brne = 1'b1;
      step(op, (op == OP_BEQ) ? 8 : 12, o);
    end else if (op == OP_ADDI) begin
      o = z(); o.asa = 1'b1; o.asb = 2'b10;
      step(op, 9, o);
      o = z(); o.rw = 1'b1;
      step(op, 10, o);
    end else begin
      o = z(); o.psrc = 2'b10; o.pcw = 1'b1;
      step(op, 11, o);
    end
  endtask

  // Apply queued cycles. Entry and exit are at posedge+1.
  task automatic run_queue(output int busy, output int rw, output int mwc,
                           output int irw, output int ill, output int berr);
    cyc_t  c;
    outs_t a;
    busy = 0; rw = 0; mwc = 0; irw = 0; ill = 0; berr = 0;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      op_i        = c.op;
      mem_ready_i = c.rdy;
      @(negedge clk);
      a = dut_outs();
      total++;
      if (state_o !== c.st || a !== c.o) begin
        bad++;
        $display("FAIL cycle op=%b rdy=%b: got state=%0d outs=%h, want state=%0d outs=%h",
                 c.op, c.rdy, state_o, a, c.st, c.o);
      end
      if (state_o != 4'd0) busy++;
      rw   += int'(reg_write_o);
      mwc  += int'(mem_write_o);
      irw  += int'(ir_write_o);
      ill  += int'(illegal_op_o);
      berr += int'(bus_err_o);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  row_t tbl[13];

  initial begin
    int busy, rw, mwc, irw, ill, berr;
    outs_t ro;

    tbl[0]  = '{"lw",        OP_LW,     0,  0,  4, 1, 0,  1, 0, 0};
    tbl[1]  = '{"sw_wait3",  OP_SW,     0,  3,  6, 0, 4,  1, 0, 0};
    tbl[2]  = '{"rtype",     OP_RTYPE,  0,  0,  3, 1, 0,  1, 0, 0};
    tbl[3]  = '{"beq_fw2",   OP_BEQ,    2,  0,  2, 0, 0,  1, 0, 0};
    tbl[4]  = '{"j",         OP_J,      0,  0,  2, 0, 0,  1, 0, 0};
    tbl[5]  = '{"addi_fw1",  OP_ADDI,   1,  0,  3, 1, 0,  1, 0, 0};
    tbl[6]  = '{"illegal",   6'b111111, 0,  0,  1, 0, 0,  1, 1, 0};
`ifdef BNE_EN
    tbl[7]  = '{"bne",       OP_BNE,    0,  0,  2, 0, 0,  1, 0, 0};
`else
    tbl[7]  = '{"bne_off",   OP_BNE,    0,  0,  1, 0, 0,  1, 1, 0};
`endif
    tbl[8]  = '{"fetch_to",  OP_J,      16, 0,  0, 0, 0,  0, 0, 1};
    tbl[9]  = '{"fetch_w15", OP_J,      15, 0,  2, 0, 0,  1, 0, 0};
    tbl[10] = '{"memrd_to",  OP_LW,     0,  16, 18, 0, 0, 1, 0, 1};
    tbl[11] = '{"memwr_to",  OP_SW,     0,  16, 18, 0, 15, 1, 0, 1};
    tbl[12] = '{"memrd_w15", OP_LW,     0,  15, 19, 1, 0, 1, 0, 0};

    // Reset state: ready high would load IR if enables were not gated
    rst_n       = 1'b0;
    op_i        = OP_RTYPE;
    mem_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ro = z(); ro.asb = 2'b01;
    total++;
    if (state_o !== 4'd0 || dut_outs() !== ro) begin
      bad++;
      $display("FAIL reset_state: got state=%0d outs=%h, want state=0 outs=%h",
               state_o, dut_outs(), ro);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed table
    foreach (tbl[i]) begin
      add_instr(tbl[i].op, tbl[i].fw, tbl[i].mw);
      run_queue(busy, rw, mwc, irw, ill, berr);
      chk({tbl[i].name, ".busy"},  busy, tbl[i].busy);
      chk({tbl[i].name, ".rw"},    rw,   tbl[i].rw);
      chk({tbl[i].name, ".mw"},    mwc,  tbl[i].mwc);
      chk({tbl[i].name, ".irw"},   irw,  tbl[i].irw);
      chk({tbl[i].name, ".ill"},   ill,  tbl[i].ill);
      chk({tbl[i].name, ".berr"},  berr, tbl[i].berr);
      $display("row %s op=%b fw=%0d mw=%0d busy=%0d rw=%0d mw=%0d ill=%0d berr=%0d",
               tbl[i].name, tbl[i].op, tbl[i].fw, tbl[i].mw, busy, rw, mwc, ill, berr);
    end

    // Randomised instruction stream against the model
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      int fw, mw, r;
      r = int'($urandom_range(0, 8));
      case (r)
        0: op = OP_RTYPE;
        1: op = OP_LW;
        2: op = OP_SW;
        3: op = OP_BEQ;
        4: op = OP_ADDI;
        5: op = OP_J;
        6: op = OP_BNE;
        default: op = 6'($urandom_range(0, 63));
      endcase
      r  = int'($urandom_range(0, 11));
      fw = (r == 0) ? 16 : (r == 1) ? 15 : int'($urandom_range(0, 3));
      r  = int'($urandom_range(0, 7));
      mw = (r == 0) ? 16 : (r == 1) ? 15 : int'($urandom_range(0, 4));
      add_instr(op, fw, mw);
      run_queue(busy, rw, mwc, irw, ill, berr);
      $display("rand %0d op=%b fw=%0d mw=%0d busy=%0d berr=%0d ill=%0d",
               n, op, fw, mw, busy, berr, ill);
    end

    // Reset asserted mid-EXEC
    op_i        = OP_RTYPE;
    mem_ready_i = 1'b1;
    @(posedge clk); #1;                 // DECODE
    @(posedge clk); #1;                 // EXEC
    chk("pre_reset_exec_state", int'(state_o), 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_async_state", int'(state_o), 0);
    chk("reset_async_we", int'({pc_write_o, branch_o, mem_write_o, ir_write_o, reg_write_o, branch_ne_w}), 0);
    @(posedge clk); #1;
    chk("reset_hold_we", int'({pc_write_o, ir_write_o, reg_write_o}), 0);
    mem_ready_i = 1'b0;
    rst_n       = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_reset_wait_state", int'(state_o), 0);
      chk("post_reset_wait_irw", int'(ir_write_o), 0);
      @(posedge clk); #1;
    end
    mem_ready_i = 1'b1;
    @(negedge clk);
    chk("post_reset_fetch_irw", int'(ir_write_o), 1);
    chk("post_reset_fetch_pcw", int'(pc_write_o), 1);
    @(posedge clk); #1;
    chk("post_reset_decode_state", int'(state_o), 1);
    $display("reset sequence done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_mc_control_fsm.md
Name: mips_mc_control_fsm

Overview:
- Parametrised main control unit for the multi-cycle, non-pipelined MIPS core. Successor to the fixed-timing decoder.
- Moore FSM sequences fetch/decode/execute/memory/writeback per instruction and drives datapath mux selects and write enables.
- Adds a ready/timeout memory handshake, so instruction/data memory of any latency is supported, plus illegal-opcode and bus-error flags.
- Sits between the instruction register opcode field and the datapath; the ALU decoder consumes alu_op_o.

Parameters:
- MIPS_OP_WIDTH, 6, opcode field width (op_i width).
- MEM_TIMEOUT, 15, max cycles waiting for mem_ready_i in any memory state before bus error; 1..255.
- TO_CNT_WIDTH, $clog2(MEM_TIMEOUT+1), width of the timeout counter (localparam).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_i  in  MIPS_OP_WIDTH  opcode from the instruction register.
- mem_ready_i  in  1  memory access completes this cycle.
- pc_write_o  out  1  unconditional PC write.
- branch_o  out  1  conditional PC write (PC written if branch_o and ALU zero).
- iord_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write_o  out  1  memory write strobe.
- ir_write_o  out  1  instruction register load.
- reg_dst_o  out  1  write register select: 0 = rt, 1 = rd.
- mem_to_reg_o  out  1  writeback data select: 0 = ALUOut, 1 = MDR.
- reg_write_o  out  1  register file write.
- alu_src_a_o  out  1  ALU A select: 0 = PC, 1 = A.
- alu_src_b_o  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_op_o  out  2  00 = add, 01 = sub, 10 = use funct.
- pc_src_o  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op_o  out  1  one-cycle pulse: undefined opcode seen in DECODE.
- bus_err_o  out  1  one-cycle pulse: memory timeout.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- State encodings 0..11: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP. 12 = BNE when BNE_EN is defined.
- Reset (rst_n low, asynchronous): state = FETCH, timeout counter = 0, flags = 0. All write enables (pc_write, ir_write, reg_write, mem_write, branch) are ANDed with rst_n, so they are 0 during reset. Selects take their FETCH values.
- FETCH: iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_src = 00. ir_write and pc_write equal mem_ready_i. Leave to DECODE on mem_ready_i, otherwise stay.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00. Next state by opcode:
  - LW/SW -> MEMADR, RTYPE -> EXEC, BEQ -> BRANCH, ADDI -> ADDIEX, J -> JUMP.
  - Any other opcode: illegal_op_o = 1 for this cycle, next state FETCH.
- MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. LW -> MEMRD, SW -> MEMWR.
- MEMRD: iord = 1. Leave to MEMWB on mem_ready_i.
- MEMWB: reg_dst = 0, mem_to_reg = 1, reg_write = 1. Next FETCH.
- MEMWR: iord = 1, mem_write = 1 held until mem_ready_i. Then FETCH.
- EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Next ALUWB.
- ALUWB: reg_dst = 1, mem_to_reg = 0, reg_write = 1. Next FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_src = 01, branch = 1. Next FETCH.
- ADDIEX: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next ADDIWB.
- ADDIWB: reg_dst = 0, mem_to_reg = 0, reg_write = 1. Next FETCH.
- JUMP: pc_src = 10, pc_write = 1. Next FETCH.
- Outputs not listed for a state are 0.
- Timeout: the counter clears on entry to each memory-wait state (FETCH, MEMRD, MEMWR) and increments each cycle mem_ready_i is low while in one.
  - If the counter reaches MEM_TIMEOUT with mem_ready_i still low: bus_err_o pulses 1 cycle and the next state is FETCH. No write enable is asserted that cycle (mem_write is forced 0).
  - mem_ready_i and the timeout in the same cycle: ready wins, no error.
- Latency: R-type 4 cycles, LW 5, SW 4, BEQ 3, ADDI 4, J 3, each with zero memory wait. Each memory state adds its wait cycles.
- Reset asserted mid-instruction: abort immediately, no partial writes after rst_n falls. Restart in FETCH when rst_n rises.

Optional Feature:
- BNE_EN defined: opcode 000101 decodes to state BNE. BNE is identical to BRANCH, but branch_o is replaced by the separate output branch_ne_o (PC written if not zero).
- BNE_EN undefined: 000101 is illegal (illegal_op_o pulses) and branch_ne_o is absent.

Test Plan:
- rst_n low mid-EXEC -> state_o = 0, all write enables 0 immediately; after release, FETCH waits for mem_ready_i.
- LW (100011), mem_ready_i always 1 -> states 0,1,2,3,4,0 over 5 cycles; MEMWB has reg_write = 1, mem_to_reg = 1.
- SW with mem_ready_i low 3 cycles in MEMWR -> mem_write = 1 for 4 cycles, then FETCH, no error.
- Opcode 111111 -> illegal_op_o = 1 for one cycle in DECODE, next state FETCH, no reg_write ever asserted.
- MEM_TIMEOUT = 15, mem_ready_i held 0 in FETCH -> bus_err_o pulses after 15 wait cycles, ir_write never 1; repeat with ready arriving on cycle 15 -> no error.
- BEQ then J -> BRANCH has alu_op = 01, branch = 1, pc_src = 01; JUMP has pc_src = 10, pc_write = 1. With BNE_EN defined, opcode 000101 -> branch_ne_o = 1.
